// File: rtl/sa_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : sa_layer_seq
// Purpose  : Layer sequencer for a systolic-array conv engine. It steps through
//            a burst table, requesting weights, streaming data and draining.
// Revision : 1.0
// ============================================================================
module sa_layer_seq #(
    parameter int NUM_LAYERS   = 4,
    parameter int BURST_W      = 11,
    parameter int ROWS         = 25,
    parameter int COLS         = 16,
    parameter int DRAIN_CYCLES = ROWS + COLS,
    localparam int LW          = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [LW-1:0]      cfg_layer,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic [LW:0]        num_layers_i,
    input  logic               start,
    input  logic               abort,
    input  logic               w_loaded_i,
    input  logic               d_valid_i,
    input  logic               burst_last_i,
    output logic               weight_start_o,
    output logic               data_enable_o,
    output logic [BURST_W-1:0] burst_size_o,
    output logic [LW-1:0]      layer_idx_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [LW:0]   MAX_LAYERS = (LW + 1)'(NUM_LAYERS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WLOAD  = 3'd1;
    localparam logic [2:0] S_WWAIT  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [BURST_W-1:0] burst_table [NUM_LAYERS];
    logic [2:0]         state;
    logic [2:0]         next_state;
    logic [LW-1:0]      layer_idx;
    logic [LW:0]        run_layers;
    logic [LW:0]        eff_layers;
    logic [BURST_W-1:0] beat_cnt;
    logic [BURST_W-1:0] beat_next;
    logic [DW-1:0]      drain_cnt;
    logic               err;
    logic               cfg_ok;
    logic               abort_hit;
    logic               last_layer;
    logic               beat_err;

    // Writes aimed past the populated table are dropped.
    if ((1 << LW) == NUM_LAYERS) begin : g_cfg_full
        assign cfg_ok = 1'b1;
    end else begin : g_cfg_part
        assign cfg_ok = ({1'b0, cfg_layer} < MAX_LAYERS);
    end

    assign burst_size_o = burst_table[layer_idx];
    assign layer_idx_o  = layer_idx;
    assign err_o        = err;
    assign abort_hit    = abort && (state != S_IDLE);
    assign last_layer   = (({1'b0, layer_idx} + (LW + 1)'(1)) >= run_layers);
    assign beat_next    = beat_cnt + BURST_W'(1);
    // A mismatched final count, or a full burst with no last marker, is an error.
    assign beat_err     = burst_last_i ? (beat_next != burst_size_o)
                                       : (beat_next == burst_size_o);

    always_comb begin
        eff_layers = num_layers_i;
        if (num_layers_i == '0) begin
            eff_layers = (LW + 1)'(1);
        end else if (num_layers_i > MAX_LAYERS) begin
            eff_layers = MAX_LAYERS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort_hit) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) next_state = S_WLOAD;
                S_WLOAD:  next_state = (burst_size_o == '0) ? S_NEXT : S_WWAIT;
                S_WWAIT:  if (w_loaded_i) next_state = S_STREAM;
                S_STREAM: if (d_valid_i && burst_last_i) next_state = S_DRAIN;
                S_DRAIN:  if (drain_cnt == DRAIN_LAST) next_state = S_NEXT;
                S_NEXT:   next_state = last_layer ? S_DONE : S_WLOAD;
                S_DONE:   next_state = S_IDLE;
                default:  next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        weight_start_o = 1'b0;
        data_enable_o  = 1'b0;
        done_o         = 1'b0;
        busy_o         = (state != S_IDLE);
        case (state)
            S_WLOAD:  weight_start_o = (burst_size_o != '0);
            S_STREAM: data_enable_o  = 1'b1;
            S_DONE:   done_o         = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                burst_table[i] <= '0;
            end
            layer_idx  <= '0;
            run_layers <= '0;
            beat_cnt   <= '0;
            drain_cnt  <= '0;
            err        <= 1'b0;
        end else begin
            if (cfg_we && (state == S_IDLE) && cfg_ok) begin
                burst_table[cfg_layer] <= cfg_burst;
            end
            if (state == S_STREAM) begin
                if (d_valid_i) begin
                    beat_cnt <= beat_next;
                end
            end else begin
                beat_cnt <= '0;
            end
            drain_cnt <= (state == S_DRAIN) ? (drain_cnt + DW'(1)) : '0;
            if (!abort_hit) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            layer_idx  <= '0;
                            err        <= 1'b0;
                            run_layers <= eff_layers;
                        end
                    end
                    S_STREAM: if (d_valid_i && beat_err) err <= 1'b1;
                    S_NEXT:   if (!last_layer) layer_idx <= layer_idx + LW'(1);
                    default:  ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sa_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_layer_seq
// Purpose  : Directed bench; a plan-level model expands each scenario into
//            per-cycle stimulus and expected outputs. Revision : 1.0
// ============================================================================
module tb_sa_layer_seq;

    localparam int DRAIN = 41;

    typedef struct packed {
        logic        rst, start, abort, wl, dv, bl, we;
        logic [1:0]  cl;
        logic [10:0] cb;
        logic [2:0]  nl;
    } stim_t;

    typedef struct packed {
        logic        ws, de;
        logic [10:0] bsz;
        logic [1:0]  idx;
        logic        busy, done, err;
    } exp_t;

    typedef int arr4_t [4];

    logic        clk = 1'b0;
    logic        rst, cfg_we, start, abort, w_loaded_i, d_valid_i, burst_last_i;
    logic [1:0]  cfg_layer;
    logic [10:0] cfg_burst;
    logic [2:0]  num_layers_i;
    logic        weight_start_o, data_enable_o, busy_o, done_o, err_o;
    logic [10:0] burst_size_o;
    logic [1:0]  layer_idx_o;

    always #5 clk = ~clk;

    sa_layer_seq dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
        .cfg_burst(cfg_burst), .num_layers_i(num_layers_i), .start(start),
        .abort(abort), .w_loaded_i(w_loaded_i), .d_valid_i(d_valid_i),
        .burst_last_i(burst_last_i), .weight_start_o(weight_start_o),
        .data_enable_o(data_enable_o), .burst_size_o(burst_size_o),
        .layer_idx_o(layer_idx_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    stim_t sq[$];
    exp_t  eq[$];
    exp_t  cur_exp;
    bit    chk = 1'b0;
    int    m_table [4];
    int    m_idx;
    bit    m_err;

    int    nvec = 0, nerr = 0, cyc = 0;
    int    cnt_ws = 0, cnt_done = 0, cnt_de = 0;
    string pin_name [64];
    int    pin_got [64], pin_want [64];
    int    pin_n = 0, pin_done = 0;

    function automatic exp_t mk(bit ws, bit de, bit busy, bit done);
        exp_t e;
        e.ws = ws; e.de = de; e.busy = busy; e.done = done;
        e.bsz = 11'(m_table[m_idx]);
        e.idx = 2'(m_idx);
        e.err = m_err;
        return e;
    endfunction

    task automatic push(input stim_t s, input exp_t e);
        sq.push_back(s);
        eq.push_back(e);
    endtask

    task automatic mreset();
        for (int i = 0; i < 4; i++) m_table[i] = 0;
        m_idx = 0;
        m_err = 1'b0;
    endtask

    task automatic plan_idle(input int n, input bit noise);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = '0;
            if (noise) begin
                s.wl = 1'b1; s.dv = i[0]; s.bl = 1'b1; s.abort = (i == 1);
            end
            push(s, mk(0, 0, 0, 0));
        end
    endtask

    task automatic plan_cfg(input int layer, input int val);
        stim_t s = '0;
        s.we = 1'b1; s.cl = 2'(layer); s.cb = 11'(val);
        push(s, mk(0, 0, 0, 0));
        m_table[layer] = val;
    endtask

    // kill: 0 none, 1 abort, 2 reset -- applied instead of beat kill_beat (0-based)
    task automatic plan_run(input int n, input int wait_c, input arr4_t beats,
                            input int kill, input int kill_layer, input int kill_beat,
                            input bit busy_cfg);
        stim_t rb, s;
        int eff, sz, b;
        eff = (n == 0) ? 1 : n;
        rb = '0; rb.nl = 3'(n);
        s = rb; s.start = 1'b1;
        push(s, mk(0, 0, 0, 0));
        m_idx = 0; m_err = 1'b0;
        for (int l = 0; l < eff; l++) begin
            m_idx = l;
            sz = m_table[l];
            push(rb, mk(sz != 0, 0, 1, 0));
            if (sz == 0) begin
                push(rb, mk(0, 0, 1, 0));
                continue;
            end
            for (int w = 0; w < wait_c; w++) begin
                s = rb; s.dv = 1'b1; s.bl = 1'b1;
                if (busy_cfg) begin s.we = 1'b1; s.cl = 2'd0; s.cb = 11'd7; end
                push(s, mk(0, 0, 1, 0));
            end
            s = rb; s.wl = 1'b1;
            push(s, mk(0, 0, 1, 0));
            b = beats[l];
            for (int k = 1; k <= b; k++) begin
                if (kill != 0 && l == kill_layer && k - 1 == kill_beat) begin
                    s = rb;
                    if (kill == 1) s.abort = 1'b1; else s.rst = 1'b1;
                    push(s, mk(0, 1, 1, 0));
                    if (kill == 2) mreset();
                    return;
                end
                s = rb; s.dv = 1'b1; s.bl = (k == b); s.wl = 1'b1;
                push(s, mk(0, 1, 1, 0));
                if ((k == b && b != sz) || (k != b && k == sz)) m_err = 1'b1;
            end
            for (int d = 0; d < DRAIN; d++) begin
                s = rb; s.dv = d[0]; s.bl = d[1];
                push(s, mk(0, 0, 1, 0));
            end
            push(rb, mk(0, 0, 1, 0));
        end
        push(rb, mk(0, 0, 1, 1));
    endtask

    task automatic plan_rst_start();
        stim_t s = '0;
        s.rst = 1'b1; s.start = 1'b1; s.abort = 1'b1; s.nl = 3'd3;
        s.we = 1'b1; s.cl = 2'd0; s.cb = 11'd9;
        push(s, mk(0, 0, 0, 0));
        mreset();
    endtask

    task automatic run_q();
        stim_t s;
        while (sq.size() > 0) begin
            @(posedge clk); #1;
            s = sq.pop_front();
            rst = s.rst; start = s.start; abort = s.abort; w_loaded_i = s.wl;
            d_valid_i = s.dv; burst_last_i = s.bl; cfg_we = s.we;
            cfg_layer = s.cl; cfg_burst = s.cb; num_layers_i = s.nl;
            cur_exp = eq.pop_front();
            chk = 1'b1;
        end
        @(negedge clk); #1;
        chk = 1'b0;
    endtask

    task automatic pin(input string nm, input int got, input int want);
        pin_name[pin_n] = nm;
        pin_got[pin_n]  = got;
        pin_want[pin_n] = want;
        pin_n++;
    endtask

    always @(negedge clk) begin
        exp_t got;
        got = {weight_start_o, data_enable_o, burst_size_o, layer_idx_o, busy_o, done_o, err_o};
        if (chk) begin
            nvec++;
            if (got !== cur_exp) begin
                nerr++;
                $display("FAIL trace cyc %0d: got ws=%0b de=%0b bsz=%0d idx=%0d busy=%0b done=%0b err=%0b, want ws=%0b de=%0b bsz=%0d idx=%0d busy=%0b done=%0b err=%0b",
                         cyc, got.ws, got.de, got.bsz, got.idx, got.busy, got.done, got.err,
                         cur_exp.ws, cur_exp.de, cur_exp.bsz, cur_exp.idx, cur_exp.busy,
                         cur_exp.done, cur_exp.err);
            end
            cnt_ws   += int'(weight_start_o === 1'b1);
            cnt_done += int'(done_o === 1'b1);
            cnt_de   += int'(data_enable_o === 1'b1);
            cyc++;
        end
        while (pin_done < pin_n) begin
            nvec++;
            if (pin_got[pin_done] != pin_want[pin_done]) begin
                nerr++;
                $display("FAIL %s: got %0d want %0d", pin_name[pin_done],
                         pin_got[pin_done], pin_want[pin_done]);
            end
            pin_done++;
        end
    end

    initial begin
        int b_ws, b_done, b_de;
        rst = 1'b1; start = 1'b0; abort = 1'b0; w_loaded_i = 1'b0; d_valid_i = 1'b0;
        burst_last_i = 1'b0; cfg_we = 1'b0; cfg_layer = '0; cfg_burst = '0; num_layers_i = '0;
        mreset();
        repeat (2) @(posedge clk);

        // Reset state, ignored strobes while idle
        plan_idle(3, 1'b1);
        run_q();

        // Three-layer nominal run with writes attempted while busy
        plan_cfg(0, 1024); plan_cfg(1, 784); plan_cfg(2, 196);
        plan_run(3, 5, '{1024, 784, 196, 0}, 0, 0, 0, 1'b1);
        plan_idle(2, 1'b0);
        b_ws = cnt_ws; b_done = cnt_done; b_de = cnt_de;
        run_q();
        pin("nominal weight_start pulses", cnt_ws - b_ws, 3);
        pin("nominal done pulses", cnt_done - b_done, 1);
        pin("nominal stream cycles", cnt_de - b_de, 2004);
        pin("nominal err", int'(err_o), 0);

        // Zero-sized middle layer is skipped
        plan_cfg(0, 3); plan_cfg(1, 0); plan_cfg(2, 5);
        plan_run(3, 2, '{3, 0, 5, 0}, 0, 0, 0, 1'b0);
        plan_idle(2, 1'b0);
        b_ws = cnt_ws; b_done = cnt_done;
        run_q();
        pin("skip weight_start pulses", cnt_ws - b_ws, 2);
        pin("skip done pulses", cnt_done - b_done, 1);
        pin("skip final layer_idx", int'(layer_idx_o), 2);

        // Short burst flags err; next start clears it; num_layers 0 runs one layer
        plan_cfg(0, 4);
        plan_run(1, 1, '{3, 0, 0, 0}, 0, 0, 0, 1'b0);
        plan_idle(1, 1'b0);
        run_q();
        pin("short burst err", int'(err_o), 1);
        plan_run(1, 0, '{4, 0, 0, 0}, 0, 0, 0, 1'b0);
        plan_idle(1, 1'b0);
        plan_run(0, 0, '{4, 0, 0, 0}, 0, 0, 0, 1'b0);
        plan_idle(1, 1'b0);
        b_done = cnt_done;
        run_q();
        pin("err cleared after restart", int'(err_o), 0);
        pin("two single-layer done pulses", cnt_done - b_done, 2);

        // Overlong burst: full count reached without last
        plan_cfg(0, 2);
        plan_run(1, 0, '{3, 0, 0, 0}, 0, 0, 0, 1'b0);
        plan_idle(1, 1'b0);
        run_q();
        pin("long burst err", int'(err_o), 1);

        // Abort in layer 1 stream, then restart from layer 0
        plan_cfg(0, 3); plan_cfg(1, 4); plan_cfg(2, 5);
        plan_run(3, 1, '{3, 4, 5, 0}, 1, 1, 2, 1'b0);
        plan_idle(2, 1'b0);
        b_done = cnt_done;
        run_q();
        pin("abort done pulses", cnt_done - b_done, 0);
        plan_run(3, 1, '{3, 4, 5, 0}, 0, 0, 0, 1'b0);
        plan_idle(1, 1'b0);
        b_ws = cnt_ws; b_done = cnt_done;
        run_q();
        pin("post-abort weight_start pulses", cnt_ws - b_ws, 3);
        pin("post-abort done pulses", cnt_done - b_done, 1);

        // Reset mid-run discards progress and the table
        plan_run(3, 0, '{3, 4, 5, 0}, 2, 0, 1, 1'b0);
        plan_idle(2, 1'b0);
        run_q();
        pin("mid-run reset burst_size", int'(burst_size_o), 0);

        // Reset together with start, abort and cfg_we
        plan_cfg(0, 3); plan_cfg(2, 6);
        plan_run(3, 0, '{3, 0, 5, 0}, 0, 0, 0, 1'b0);
        plan_idle(1, 1'b0);
        plan_rst_start();
        plan_idle(2, 1'b0);
        run_q();
        pin("rst+start busy", int'(busy_o), 0);
        pin("rst+start burst_size", int'(burst_size_o), 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sa_layer_seq.md
SA_LAYER_SEQ -- requirements
Module: sa_layer_seq

Interface
REQ-001 Parameter NUM_LAYERS, default 4: number of programmable conv layers; valid range 1..16.
REQ-002 Parameter BURST_W, default 11: width of the per-layer burst-size field.
REQ-003 Parameter ROWS, default 25: systolic-array data band width.
REQ-004 Parameter COLS, default 16: systolic-array column count.
REQ-005 Parameter DRAIN_CYCLES, default ROWS+COLS: post-burst pipeline flush length.
REQ-006 Port list; LW = clog2(NUM_LAYERS):
- clk  in  1  sole clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  burst-table write strobe.
- cfg_layer  in  LW  burst-table write index.
- cfg_burst  in  BURST_W  burst size for the indexed layer.
- num_layers_i  in  LW+1  layers to run per start; 0 is treated as 1.
- start  in  1  start pulse.
- abort  in  1  abort pulse.
- w_loaded_i  in  1  weight buffer reports the current layer is loaded.
- d_valid_i  in  1  data-setup beat valid.
- burst_last_i  in  1  data-setup last beat.
- weight_start_o  out  1  one-cycle weight-load request.
- data_enable_o  out  1  data streaming permitted.
- burst_size_o  out  BURST_W  active layer burst size.
- layer_idx_o  out  LW  active layer index.
- busy_o  out  1  sequencer not idle.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky beat-count mismatch flag.

Function
REQ-007 The block SHALL hold a NUM_LAYERS x BURST_W burst table, written on cfg_we only while busy_o=0; writes while busy SHALL be ignored.
REQ-008 The FSM states SHALL be IDLE, WLOAD, WWAIT, STREAM, DRAIN, NEXT and DONE.
REQ-009 IDLE: a start pulse SHALL clear layer_idx_o to 0, clear err_o and go to WLOAD; start in any other state SHALL be ignored.
REQ-010 WLOAD: weight_start_o=1 for exactly one cycle, then WWAIT.
REQ-011 WWAIT: the FSM SHALL wait for w_loaded_i=1, then go to STREAM the next cycle.
REQ-012 STREAM: data_enable_o=1 and a beat counter SHALL increment on each d_valid_i.
- On d_valid_i & burst_last_i, go to DRAIN.
- If final count != burst_size_o, err_o SHALL set.
REQ-013 In STREAM, d_valid_i without burst_last_i at count = burst_size_o-1 SHALL set err_o; the FSM SHALL continue to wait for burst_last_i.
REQ-014 DRAIN: data_enable_o=0 for exactly DRAIN_CYCLES cycles, then NEXT.
REQ-015 NEXT: layer_idx_o+1 >= effective num_layers -> DONE; otherwise increment layer_idx_o and go to WLOAD.
REQ-016 A layer whose table entry is 0 SHALL be skipped: WLOAD goes directly to NEXT, with no weight_start_o and no streaming.
REQ-017 DONE: done_o=1 for one cycle, then IDLE.
REQ-018 burst_size_o SHALL equal table[layer_idx_o] combinationally; the beat counter SHALL be BURST_W bits wide and reset to 0 on entry to STREAM.
REQ-019 abort in any non-IDLE state SHALL force IDLE next cycle.
- No done_o is produced; err_o is retained.
- abort has priority over all other transitions.
REQ-020 busy_o SHALL be 1 in every state except IDLE.
REQ-021 d_valid_i, burst_last_i and w_loaded_i outside their consuming state SHALL be ignored.

Reset
REQ-022 On rst=1, the block SHALL enter IDLE with all outputs 0 and layer_idx_o=0.
REQ-023 On rst=1, every table entry SHALL be cleared to 0.
REQ-024 rst SHALL win over start, abort and cfg_we in the same cycle; reset mid-run SHALL discard all progress.

Verification
REQ-025 Table = {1024, 784, 196}, num_layers_i=3, start, w_loaded_i after 5 cycles, exact beats per layer -> three weight_start_o pulses, layer_idx_o stepping 0/1/2, DRAIN of 41 cycles each, one done_o, err_o=0.
REQ-026 Layer 1 entry = 0, num_layers_i=3 -> only two weight_start_o pulses; layer_idx_o steps 0->1->2; done_o asserted.
REQ-027 burst_size = 4, burst_last_i on beat 3 -> err_o=1 after the beat, the sequence still completes, err_o is cleared on the next start.
REQ-028 abort during STREAM of layer 1 -> busy_o=0 next cycle, no done_o; a subsequent start restarts at layer 0.
REQ-029 cfg_we while busy -> table unchanged; rst asserted together with start -> IDLE, all outputs 0, table cleared.
